// File: rtl/ramp_target_decoder.sv
// ramp_target_decoder: recovers the target T from a 0,1,..,T,0,.. ramp stream.
// The decoder locks once LOCK_COUNT consecutive complete ramps agree on T.
// An illegal step raises err and drops the decoder back to hunting for a zero.
module ramp_target_decoder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] target_out,
  output logic             target_valid,
  output logic             locked,
  output logic             err
);

  // Wide enough for LOCK_COUNT up to 15.
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RAMP = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_match_cnt;
  logic [WIDTH-1:0] r_target;
  logic             r_target_valid;
  logic             r_locked;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [CNT_W-1:0] w_match_nxt;
  logic [WIDTH-1:0] w_target_nxt;
  logic             w_target_valid_nxt;
  logic             w_locked_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_prev_inc;

  // Expected next ramp value; wraps modulo 2^WIDTH.
  assign w_prev_inc = r_prev + WIDTH'(1);

  // State and output registers; reset has priority over sample_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= HUNT;
      r_prev         <= '0;
      r_cand         <= '0;
      r_match_cnt    <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_prev         <= w_prev_nxt;
      r_cand         <= w_cand_nxt;
      r_match_cnt    <= w_match_nxt;
      r_target       <= w_target_nxt;
      r_target_valid <= w_target_valid_nxt;
      r_locked       <= w_locked_nxt;
      r_err          <= w_err_nxt;
    end
  end

  // Next-state and output decode for one accepted sample; pulses clear otherwise.
  always_comb begin
    w_state_nxt        = r_state;
    w_prev_nxt         = r_prev;
    w_cand_nxt         = r_cand;
    w_match_nxt        = r_match_cnt;
    w_target_nxt       = r_target;
    w_locked_nxt       = r_locked;
    w_target_valid_nxt = 1'b0;
    w_err_nxt          = 1'b0;

    if (sample_valid) begin
      unique case (r_state)
        HUNT: begin
          // Only a zero can start a ramp; it yields no candidate.
          if (sample_in == '0) begin
            w_prev_nxt  = '0;
            w_state_nxt = RAMP;
          end
        end
        RAMP, LOCK: begin
          if (sample_in == '0) begin
            // End of ramp: the candidate target is the last sample seen.
            w_prev_nxt = '0;
            if (r_prev == r_cand) begin
              w_match_nxt = (r_match_cnt >= LOCK_CNT) ? LOCK_CNT
                                                      : r_match_cnt + CNT_W'(1);
            end else begin
              w_cand_nxt   = r_prev;
              w_match_nxt  = CNT_W'(1);
              w_locked_nxt = 1'b0;
              w_state_nxt  = RAMP;
            end
            if (w_match_nxt >= LOCK_CNT) begin
              w_locked_nxt       = 1'b1;
              w_target_nxt       = r_prev;
              w_target_valid_nxt = 1'b1;
              w_state_nxt        = LOCK;
            end
          end else if (sample_in == w_prev_inc) begin
            w_prev_nxt = sample_in;
          end else begin
            // Illegal step: drop lock and re-synchronise; target_out holds.
            w_err_nxt    = 1'b1;
            w_locked_nxt = 1'b0;
            w_match_nxt  = '0;
            w_state_nxt  = HUNT;
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  assign target_out   = r_target;
  assign target_valid = r_target_valid;
  assign locked       = r_locked;
  assign err          = r_err;

endmodule
